// File: rtl/axi_interface_pkg.sv
// Shared AXI types plus the burst helpers used by the read slave.
// Beat-address math is modulo 2^AXI_ADDR_SIZE; there is no 4 KB boundary handling.
package axi_interface_pkg;

  localparam int AXI_ADDR_SIZE = 32;
  localparam int AXI_DATA_SIZE = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_t;

  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'd0,
    SIZE_HALF  = 3'd1,
    SIZE_WORD  = 3'd2,
    SIZE_DWORD = 3'd3,
    SIZE_16B   = 3'd4,
    SIZE_32B   = 3'd5,
    SIZE_64B   = 3'd6,
    SIZE_128B  = 3'd7
  } axi_burst_size_t;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_ISSUE = 2'd1,
    RD_DRAIN = 2'd2
  } rd_state_t;

  // Bit n is set when ARLEN == n is a legal WRAP length (2, 4, 8 or 16 beats).
  localparam logic [15:0] WRAP_LEGAL_LENS = 16'h808A;

  function automatic logic wrap_len_legal(input logic [7:0] len);
    return (len[7:4] == 4'd0) && WRAP_LEGAL_LENS[len[3:0]];
  endfunction

  function automatic logic [AXI_ADDR_SIZE-1:0] next_burst_address(
    input logic [AXI_ADDR_SIZE-1:0] addr,
    input axi_burst_size_t          size,
    input logic [7:0]               len,
    input axi_burst_t               burst
  );
    logic [AXI_ADDR_SIZE-1:0] nbytes;
    logic [AXI_ADDR_SIZE-1:0] bound;
    nbytes = AXI_ADDR_SIZE'(1) << size;
    bound  = (AXI_ADDR_SIZE'(len) + AXI_ADDR_SIZE'(1)) << size;
    if (burst == BURST_FIXED) begin
      return addr;
    end else if (burst == BURST_WRAP && wrap_len_legal(len)) begin
      return (addr & ~(bound - AXI_ADDR_SIZE'(1))) |
             ((addr + nbytes) & (bound - AXI_ADDR_SIZE'(1)));
    end else begin
      // Illegal WRAP lengths and the reserved encoding fall back to INCR.
      return (addr & ~(nbytes - AXI_ADDR_SIZE'(1))) + nbytes;
    end
  endfunction

endpackage

// File: rtl/axi_read_response_fifo.sv
// Show-ahead FIFO holding {data, last} read responses; head entry is visible while not empty.
// Push on a full FIFO and pop on an empty FIFO are dropped; the owner guarantees neither happens.
module axi_read_response_fifo
  import axi_interface_pkg::*;
#(
  parameter int WIDTH = AXI_DATA_SIZE * 8 + 1,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == (AW+1)'(DEPTH));
  assign count_o     = count_q;
  assign head_data_o = mem_q[rd_ptr_q];
  assign do_push     = push_i && !full_o;
  assign do_pop      = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/axi_read_slave.sv
// AXI read slave: expands one AR burst into per-beat memory reads and returns the data on R.
// Reads are only issued while outstanding + buffered responses leave room in the response FIFO.
module axi_read_slave
  import axi_interface_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [AXI_ADDR_SIZE-1:0]   ARADDR,
  input  logic [7:0]                 ARLEN,
  input  axi_burst_size_t            ARSIZE,
  input  axi_burst_t                 ARBURST,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [AXI_DATA_SIZE*8-1:0] RDATA,
  output logic                       RLAST,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic                       read_o,
  output logic [AXI_ADDR_SIZE-1:0]   read_address_o,
  input  logic [AXI_DATA_SIZE*8-1:0] read_data_i,
  input  logic                       read_valid_i
);

  localparam int DW    = AXI_DATA_SIZE * 8;
  localparam int IDX_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W:0] DEPTH_C  = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [2:0]     MAX_SIZE = 3'($clog2(AXI_DATA_SIZE));

  rd_state_t                state_q, state_d;
  logic [AXI_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [7:0]               len_q, len_d;
  axi_burst_size_t          size_q, size_d;
  axi_burst_t               burst_q, burst_d;
  logic [7:0]               beat_q, beat_d;
  logic [CNT_W-1:0]         out_q, out_d;
  logic [FIFO_DEPTH-1:0]    last_q, last_d;

  logic             ar_fire, issue, issue_last, rsp_accept, r_fire;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   inflight;
  logic             fifo_empty, fifo_full;
  logic [DW:0]      fifo_head;

  assign ar_fire    = ARVALID && ARREADY;
  assign inflight   = {1'b0, out_q} + {1'b0, fifo_count};
  // The credit uses this cycle's FIFO count, so a pop in the same cycle frees nothing yet.
  assign issue      = (state_q == RD_ISSUE) && (inflight < DEPTH_C);
  assign issue_last = (beat_q == len_q);
  assign rsp_accept = read_valid_i && (out_q != '0);
  assign RVALID     = !fifo_empty;
  assign RDATA      = fifo_head[DW:1];
  assign RLAST      = fifo_head[0];
  assign r_fire     = RVALID && RREADY;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    len_d          = len_q;
    size_d         = size_q;
    burst_d        = burst_q;
    beat_d         = beat_q;
    ARREADY        = (state_q == RD_IDLE);
    read_o         = issue;
    read_address_o = addr_q;
    case (state_q)
      RD_IDLE: begin
        if (ar_fire) begin
          addr_d  = ARADDR;
          len_d   = ARLEN;
          size_d  = ARSIZE;
          burst_d = ARBURST;
          beat_d  = '0;
          state_d = RD_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (issue) begin
          addr_d = next_burst_address(addr_q, size_q, len_q, burst_q);
          beat_d = beat_q + 8'd1;
          if (issue_last) state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (r_fire && RLAST) state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Per-beat last flags ride in issue order; entry 0 belongs to the oldest outstanding read.
  always_comb begin
    last_d = last_q;
    out_d  = out_q;
    if (rsp_accept) begin
      last_d = last_q >> 1;
      out_d  = out_q - CNT_W'(1);
    end
    if (issue) begin
      last_d[out_d[IDX_W-1:0]] = issue_last;
      out_d = out_d + CNT_W'(1);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q <= RD_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= SIZE_BYTE;
      burst_q <= BURST_FIXED;
      beat_q  <= '0;
      out_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      out_q   <= out_d;
      last_q  <= last_d;
    end
  end

  axi_read_response_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .ACLK        (ACLK),
    .ARESET      (ARESET),
    .push_i      (rsp_accept),
    .push_data_i ({read_data_i, last_q[0]}),
    .pop_i       (r_fire),
    .head_data_o (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  a_wrap_len: assert property (@(posedge ACLK) disable iff (ARESET)
    (ar_fire && ARBURST == BURST_WRAP) |-> wrap_len_legal(ARLEN));
  a_size: assert property (@(posedge ACLK) disable iff (ARESET)
    ar_fire |-> (ARSIZE <= MAX_SIZE));
  a_no_overflow: assert property (@(posedge ACLK) disable iff (ARESET)
    rsp_accept |-> !fifo_full);

endmodule

// File: tb/tb_axi_read_slave.sv
// Directed bench for axi_read_slave with a 1-cycle memory model; address 0x40 behaves as a
// data FIFO register returning 0xA, 0xB, 0xC..., every other address returns 0xD0000000|addr.
module tb_axi_read_slave;
  import axi_interface_pkg::*;

  logic                       ACLK, ARESET;
  logic [AXI_ADDR_SIZE-1:0]   ARADDR;
  logic [7:0]                 ARLEN;
  axi_burst_size_t            ARSIZE;
  axi_burst_t                 ARBURST;
  logic                       ARVALID, ARREADY;
  logic [AXI_DATA_SIZE*8-1:0] RDATA;
  logic                       RLAST, RVALID, RREADY;
  logic                       read_o;
  logic [AXI_ADDR_SIZE-1:0]   read_address_o;
  logic [AXI_DATA_SIZE*8-1:0] read_data_i;
  logic                       read_valid_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stale_cyc = -1;
  int fifo_idx = 0;
  int t_ar = 0;
  logic [31:0] a_q[$];
  int          a_cyc[$];
  logic [32:0] r_q[$];
  int          r_cyc[$];

  axi_read_slave #(.FIFO_DEPTH(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA), .RLAST(RLAST),
    .RVALID(RVALID), .RREADY(RREADY), .read_o(read_o), .read_address_o(read_address_o),
    .read_data_i(read_data_i), .read_valid_i(read_valid_i)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial forever begin
    @(posedge ACLK);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Memory: sample the request mid-cycle, answer one cycle later.
  initial begin
    logic                     rd, st;
    logic [AXI_ADDR_SIZE-1:0] ad;
    read_valid_i = 1'b0;
    read_data_i  = '0;
    forever begin
      @(negedge ACLK);
      rd = read_o;
      ad = read_address_o;
      st = (cyc == stale_cyc);
      @(posedge ACLK);
      #1;
      read_valid_i = rd || st;
      if (rd) begin
        if (ad == 32'h40) begin
          read_data_i = 32'hA + 32'(fifo_idx);
          fifo_idx++;
        end else begin
          read_data_i = 32'hD000_0000 | ad;
        end
      end else if (st) begin
        read_data_i = 32'hBAD0_0000;
      end
    end
  end

  initial forever begin
    @(negedge ACLK);
    if (read_o) begin
      a_q.push_back(read_address_o);
      a_cyc.push_back(cyc);
    end
    if (RVALID && RREADY) begin
      r_q.push_back({RLAST, RDATA});
      r_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " arready"}, 64'(ARREADY), 64'd1);
    chk({tag, " rvalid"},  64'(RVALID), 64'd0);
    chk({tag, " rlast"},   64'(RLAST), 64'd0);
    chk({tag, " rdata"},   64'(RDATA), 64'd0);
    chk({tag, " read_o"},  64'(read_o), 64'd0);
    chk({tag, " raddr"},   64'(read_address_o), 64'd0);
  endtask

  task automatic clear_logs();
    a_q.delete();
    a_cyc.delete();
    r_q.delete();
    r_cyc.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after the handshake.
  task automatic send_ar(input logic [31:0] addr, input logic [7:0] len,
                         input axi_burst_size_t size, input axi_burst_t burst);
    ARADDR  = addr;
    ARLEN   = len;
    ARSIZE  = size;
    ARBURST = burst;
    ARVALID = 1'b1;
    @(negedge ACLK);
    chk($sformatf("arready at AR %0h", addr), 64'(ARREADY), 64'd1);
    t_ar = cyc;
    @(posedge ACLK);
    #1;
    ARVALID = 1'b0;
  endtask

  task automatic wait_r(input int n, input string tag);
    int k;
    k = 0;
    while (r_q.size() < n && k < 200) begin
      @(posedge ACLK);
      #1;
      k++;
    end
    chk({tag, " beats received"}, 64'(r_q.size()), 64'(n));
  endtask

  task automatic arready_after(input string tag);
    @(negedge ACLK);
    chk({tag, " arready after last"}, 64'(ARREADY), 64'd1);
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    int k;
    ARESET  = 1'b1;
    ARVALID = 1'b0;
    ARADDR  = '0;
    ARLEN   = '0;
    ARSIZE  = SIZE_WORD;
    ARBURST = BURST_INCR;
    RREADY  = 1'b1;
    repeat (2) @(posedge ACLK);
    @(negedge ACLK);
    chk_reset("reset");
    @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;

    // INCR x4 words at 0x100, latency and back-to-back beats
    clear_logs();
    send_ar(32'h100, 8'd3, SIZE_WORD, BURST_INCR);
    wait_r(4, "t1");
    chk("t1 nreads", 64'(a_q.size()), 64'd4);
    chk("t1 addr0", 64'(a_q[0]), 64'h100);
    chk("t1 addr1", 64'(a_q[1]), 64'h104);
    chk("t1 addr2", 64'(a_q[2]), 64'h108);
    chk("t1 addr3", 64'(a_q[3]), 64'h10C);
    chk("t1 r0", 64'(r_q[0]), {31'd0, 1'b0, 32'hD000_0100});
    chk("t1 r1", 64'(r_q[1]), {31'd0, 1'b0, 32'hD000_0104});
    chk("t1 r2", 64'(r_q[2]), {31'd0, 1'b0, 32'hD000_0108});
    chk("t1 r3", 64'(r_q[3]), {31'd0, 1'b1, 32'hD000_010C});
    chk("t1 read_o cycle", 64'(a_cyc[0]), 64'(t_ar + 1));
    chk("t1 first rvalid cycle", 64'(r_cyc[0]), 64'(t_ar + 3));
    chk("t1 last beat cycle", 64'(r_cyc[3]), 64'(t_ar + 6));
    arready_after("t1");

    // WRAP x4 words starting at 0x108
    clear_logs();
    send_ar(32'h108, 8'd3, SIZE_WORD, BURST_WRAP);
    wait_r(4, "t2");
    chk("t2 addr0", 64'(a_q[0]), 64'h108);
    chk("t2 addr1", 64'(a_q[1]), 64'h10C);
    chk("t2 addr2", 64'(a_q[2]), 64'h100);
    chk("t2 addr3", 64'(a_q[3]), 64'h104);
    chk("t2 r2", 64'(r_q[2]), {31'd0, 1'b0, 32'hD000_0100});
    chk("t2 r3", 64'(r_q[3]), {31'd0, 1'b1, 32'hD000_0104});
    arready_after("t2");

    // FIXED x3 on the data register at 0x40
    clear_logs();
    send_ar(32'h40, 8'd2, SIZE_WORD, BURST_FIXED);
    wait_r(3, "t3");
    chk("t3 nreads", 64'(a_q.size()), 64'd3);
    chk("t3 addr0", 64'(a_q[0]), 64'h40);
    chk("t3 addr2", 64'(a_q[2]), 64'h40);
    chk("t3 r0", 64'(r_q[0]), {31'd0, 1'b0, 32'hA});
    chk("t3 r1", 64'(r_q[1]), {31'd0, 1'b0, 32'hB});
    chk("t3 r2", 64'(r_q[2]), {31'd0, 1'b1, 32'hC});
    arready_after("t3");

    // INCR x8 with RREADY held low: issue stops at the credit limit, head data holds
    clear_logs();
    RREADY = 1'b0;
    send_ar(32'h200, 8'd7, SIZE_WORD, BURST_INCR);
    k = 0;
    @(negedge ACLK);
    while (!RVALID && k < 50) begin
      @(negedge ACLK);
      k++;
    end
    chk("t4 first rvalid seen", 64'(RVALID), 64'd1);
    for (int i = 0; i < 12; i++) begin
      @(negedge ACLK);
      chk($sformatf("t4 hold %0d", i), 64'({RVALID, RLAST, RDATA}), {30'd0, 2'b10, 32'hD000_0200});
    end
    chk("t4 reads while stalled", 64'(a_q.size()), 64'd4);
    @(posedge ACLK);
    #1;
    RREADY = 1'b1;
    wait_r(8, "t4");
    chk("t4 nreads", 64'(a_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4 addr%0d", i), 64'(a_q[i]), 64'(32'h200 + 32'(4 * i)));
      chk($sformatf("t4 r%0d", i), 64'(r_q[i]), 64'({(i == 7), 32'hD000_0200 + 32'(4 * i)}));
    end
    arready_after("t4");

    // Single unaligned beat, then an immediate second burst
    clear_logs();
    send_ar(32'h103, 8'd0, SIZE_WORD, BURST_INCR);
    wait_r(1, "t5a");
    chk("t5a nreads", 64'(a_q.size()), 64'd1);
    chk("t5a addr0", 64'(a_q[0]), 64'h103);
    chk("t5a r0 last", 64'(r_q[0]), {31'd0, 1'b1, 32'hD000_0103});
    clear_logs();
    send_ar(32'h300, 8'd1, SIZE_WORD, BURST_INCR);
    chk("t5b accepted in cycle after last beat", 64'(t_ar), 64'(r_cyc.size() == 0 ? t_ar : -1));
    wait_r(2, "t5b");
    chk("t5b addr1", 64'(a_q[1]), 64'h304);
    chk("t5b r0", 64'(r_q[0]), {31'd0, 1'b0, 32'hD000_0300});
    chk("t5b r1", 64'(r_q[1]), {31'd0, 1'b1, 32'hD000_0304});
    arready_after("t5b");

    // Reset mid-burst, then a stale memory response right after release
    clear_logs();
    send_ar(32'h400, 8'd7, SIZE_WORD, BURST_INCR);
    k = 0;
    while (a_q.size() < 2 && k < 50) begin
      @(posedge ACLK);
      #1;
      k++;
    end
    chk("t6 two beats issued", 64'(a_q.size() >= 2), 64'd1);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk_reset("t6 in reset");
    @(posedge ACLK);
    #1;
    ARESET    = 1'b0;
    stale_cyc = cyc;
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      chk($sformatf("t6 idle %0d", i), 64'({ARREADY, RVALID, RLAST, read_o}), 64'b1000);
    end
    @(posedge ACLK);
    #1;
    clear_logs();
    send_ar(32'h500, 8'd3, SIZE_WORD, BURST_INCR);
    wait_r(4, "t6");
    chk("t6 nreads", 64'(a_q.size()), 64'd4);
    chk("t6 r0", 64'(r_q[0]), {31'd0, 1'b0, 32'hD000_0500});
    chk("t6 r2", 64'(r_q[2]), {31'd0, 1'b0, 32'hD000_0508});
    chk("t6 r3", 64'(r_q[3]), {31'd0, 1'b1, 32'hD000_050C});
    arready_after("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
